// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state type, default cell width and cell addressing helper
// for the systolic array front-end blocks.
package systolic_pkg;

    typedef enum logic {IDLE, STREAM} state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Row-major cell index of (row, col) in a matrix with `cols` columns.
    function automatic int cell_idx(int row, int col, int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/matrix_skew_buffer_if.sv
// matrix_skew_buffer_if: host/stream bundle of the matrix skew buffer.
//   master (host side) drives : wr_en, wr_addr, wr_data, start, rd_row [, transpose]
//   slave  (buffer side) drives: wr_reject, load_done, busy, done, skew_out, skew_valid, row_out
//   transpose exists only when MATRIX_SKEW_TRANSPOSE_EN is defined.
interface matrix_skew_buffer_if
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = DEFAULT_DATA_W
);
    localparam int ADDR_W = $clog2(ROWS * COLS);
    localparam int RSEL_W = ROWS > 1 ? $clog2(ROWS) : 1;

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_reject;
    logic                     load_done;
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [ROWS*DATA_W-1:0]   skew_out;
    logic [ROWS-1:0]          skew_valid;
    logic [RSEL_W-1:0]        rd_row;
    logic [COLS*DATA_W-1:0]   row_out;
`ifdef MATRIX_SKEW_TRANSPOSE_EN
    logic                     transpose;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, start, rd_row,
`ifdef MATRIX_SKEW_TRANSPOSE_EN
        output transpose,
`endif
        input  wr_reject, load_done, busy, done, skew_out, skew_valid, row_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, rd_row,
`ifdef MATRIX_SKEW_TRANSPOSE_EN
        input  transpose,
`endif
        output wr_reject, load_done, busy, done, skew_out, skew_valid, row_out
    );

endinterface

// File: rtl/skew_lane_mux.sv
// skew_lane_mux: combinational element picker for one systolic lane.
//   k         in  stream cycle index
//   lane      in  lane number r
//   matrix    in  flattened row-major matrix, cell i at [i*DATA_W +: DATA_W]
//   transpose in  1: pick A[k-r][r], 0: pick A[r][k-r]
//   data      out selected cell, 0 when not valid
//   valid     out 0 <= k-r < COLS
module skew_lane_mux
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = DEFAULT_DATA_W,
    localparam int ADDR_W = $clog2(ROWS * COLS),
    localparam int RSEL_W = ROWS > 1 ? $clog2(ROWS) : 1,
    localparam int CNT_W  = $clog2(ROWS + COLS)
) (
    input  logic [CNT_W-1:0]            k,
    input  logic [RSEL_W-1:0]           lane,
    input  logic [ROWS*COLS*DATA_W-1:0] matrix,
    input  logic                        transpose,
    output logic [DATA_W-1:0]           data,
    output logic                        valid
);
    logic [DATA_W-1:0] cells [ROWS*COLS];
    logic [ADDR_W-1:0] idx;
    int                d;

    for (genvar i = 0; i < ROWS * COLS; i++) begin : g_cell
        assign cells[i] = matrix[i*DATA_W +: DATA_W];
    end

    always_comb begin
        d     = int'(k) - int'(lane);
        valid = d >= 0 && d < COLS;
        idx   = valid ? ADDR_W'(transpose ? cell_idx(d, int'(lane), COLS)
                                          : cell_idx(int'(lane), d, COLS)) : '0;
        data  = valid ? cells[idx] : '0;
    end

endmodule

// File: rtl/matrix_skew_buffer.sv
// matrix_skew_buffer: ROWSxCOLS cell buffer loaded by address, streamed diagonally
// skewed (lane r delayed r cycles) into the left edge of a systolic PE array.
//   clk   in  rising-edge clock
//   reset in  asynchronous active-high reset
//   bus   slave modport of matrix_skew_buffer_if (write port, stream control,
//         skewed lane outputs, registered raw row readback)
// Optional: MATRIX_SKEW_TRANSPOSE_EN adds bus.transpose (stream columns instead of rows).
module matrix_skew_buffer
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    matrix_skew_buffer_if.slave  bus
);
    localparam int NCELL  = ROWS * COLS;
    localparam int ADDR_W = $clog2(NCELL);
    localparam int RSEL_W = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CNT_W  = $clog2(ROWS + COLS);
    localparam int T      = ROWS + COLS - 1;

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d, k;
    logic [NCELL*DATA_W-1:0] matrix, matrix_nxt;
    logic [NCELL-1:0]        written, hit;
    logic                    accept, last, emit, wr_ok, tr;
    logic [ROWS*DATA_W-1:0]  lane_data;
    logic [ROWS-1:0]         lane_valid;
    logic [COLS*DATA_W-1:0]  rows [2**RSEL_W];

`ifdef MATRIX_SKEW_TRANSPOSE_EN
    logic tr_q;
    if (ROWS != COLS) begin : g_shape_check
        $error("matrix_skew_buffer: transpose needs a square matrix");
    end
    // Orientation is latched on the accept edge and held for the whole stream.
    assign tr = accept ? bus.transpose : tr_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) tr_q <= 1'b0;
        else tr_q <= tr;
`else
    assign tr = 1'b0;
`endif

    assign wr_ok = bus.wr_en && state == IDLE && |hit;

    // Out-of-range addresses match no cell, so |hit doubles as the range check.
    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        logic [DATA_W-1:0] q;
        assign hit[i] = bus.wr_addr == ADDR_W'(i);
        always_ff @(posedge clk or posedge reset)
            if (reset) q <= '0;
            else if (wr_ok && hit[i]) q <= bus.wr_data;
        assign matrix[i*DATA_W +: DATA_W] = q;
        // The stream taps next-state contents so a write in the start cycle is seen.
        assign matrix_nxt[i*DATA_W +: DATA_W] = wr_ok && hit[i] ? bus.wr_data : q;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end

    // cnt holds the index of the next stream cycle to be registered.
    always_comb begin
        accept  = state == IDLE && bus.start;
        last    = state == STREAM && cnt == CNT_W'(T);
        emit    = accept || (state == STREAM && !last);
        state_d = accept ? STREAM : last ? IDLE : state;
        cnt_d   = accept ? CNT_W'(1) : emit ? cnt + 1'b1 : cnt;
        k       = accept ? '0 : cnt;
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        skew_lane_mux #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W)) u_mux (
            .k         (k),
            .lane      (RSEL_W'(i)),
            .matrix    (matrix_nxt),
            .transpose (tr),
            .data      (lane_data[i*DATA_W +: DATA_W]),
            .valid     (lane_valid[i])
        );
    end

    // Row table padded to the full select range so rd_row >= ROWS reads 0.
    for (genvar i = 0; i < 2**RSEL_W; i++) begin : g_row
        if (i < ROWS) begin : g_real
            assign rows[i] = matrix[i*COLS*DATA_W +: COLS*DATA_W];
        end else begin : g_pad
            assign rows[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            bus.skew_out   <= '0;
            bus.skew_valid <= '0;
            bus.done       <= 1'b0;
            bus.wr_reject  <= 1'b0;
            bus.row_out    <= '0;
            written        <= '0;
        end else begin
            bus.skew_out   <= emit ? lane_data : '0;
            bus.skew_valid <= emit ? lane_valid : '0;
            bus.done       <= last;
            bus.wr_reject  <= bus.wr_en && !wr_ok;
            bus.row_out    <= rows[bus.rd_row];
            written        <= last ? '0 : wr_ok ? written | hit : written;
        end

    assign bus.busy      = state == STREAM;
    assign bus.load_done = &written;

endmodule

// File: tb/tb_matrix_skew_buffer.sv
// tb_matrix_skew_buffer: directed bench for matrix_skew_buffer (4x4 main instance,
// 3x3 instance for out-of-range address and row select).
module tb_matrix_skew_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   done_seen;

    always #5 clk = ~clk;

    matrix_skew_buffer_if #(.ROWS(4), .COLS(4), .DATA_W(8)) bus ();
    matrix_skew_buffer_if #(.ROWS(3), .COLS(3), .DATA_W(8)) bus_s ();

    matrix_skew_buffer #(.ROWS(4), .COLS(4), .DATA_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    matrix_skew_buffer #(.ROWS(3), .COLS(3), .DATA_W(8)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    // Expected skewed stream of A[r][c] = r*4 + c + 1.
    logic [31:0] exp_data  [7] = '{32'h00000001, 32'h00000502, 32'h00090603, 32'h0D0A0704,
                                   32'h0E0B0800, 32'h0F0C0000, 32'h10000000};
    logic [3:0]  exp_valid [7] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                   4'b1110, 4'b1100, 4'b1000};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 16; a++) write(a, 8'(a + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active, finish required");
        $fatal(1);
    end

    initial begin
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.start = 0; bus.rd_row = 0;
        bus_s.wr_en = 0; bus_s.wr_addr = 0; bus_s.wr_data = 0; bus_s.start = 0; bus_s.rd_row = 0;
`ifdef MATRIX_SKEW_TRANSPOSE_EN
        bus.transpose = 0;
        bus_s.transpose = 0;
`endif
        repeat (2) step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_skew_valid", bus.skew_valid, 0);
        chk("rst_skew_out", bus.skew_out, 0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_row_out", bus.row_out, 0);
        reset = 0;
        step();

        // Reset in the middle of a load wipes the cells.
        write(0, 8'h55);
        write(1, 8'h66);
        step();
        chk("midload_row0", bus.row_out, 32'h00006655);
        reset = 1;
        #1;
        chk("midload_rst_row_out", bus.row_out, 0);
        step();
        reset = 0;
        step();
        chk("midload_cells_cleared", bus.row_out, 0);
        chk("midload_load_done", bus.load_done, 0);

        for (int a = 0; a < 15; a++) write(a, 8'(a + 1));
        chk("load15_load_done", bus.load_done, 0);
        write(15, 8'h10);
        chk("load16_load_done", bus.load_done, 1);
        bus.rd_row = 2;
        step();
        chk("row2", bus.row_out, 32'h0C0B0A09);
        bus.rd_row = 3;
        step();
        chk("row3", bus.row_out, 32'h100F0E0D);

        // Full stream, with a rejected write and an ignored start while busy.
        bus.start = 1;
        step();
        bus.start = 0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("s1_busy_k%0d", k), bus.busy, 1);
            chk($sformatf("s1_valid_k%0d", k), bus.skew_valid, exp_valid[k]);
            chk($sformatf("s1_data_k%0d", k), bus.skew_out, exp_data[k]);
            if (k == 1) begin
                bus.wr_en = 1; bus.wr_addr = 4'd5; bus.wr_data = 8'hFF;
            end
            if (k == 2) begin
                chk("busy_wr_reject", bus.wr_reject, 1);
                bus.wr_en = 0;
            end
            if (k == 3) chk("wr_reject_pulse_end", bus.wr_reject, 0);
            if (k == 4) bus.start = 1;
            if (k == 5) bus.start = 0;
            step();
        end
        chk("s1_done", bus.done, 1);
        chk("s1_done_busy", bus.busy, 0);
        chk("s1_done_load_done", bus.load_done, 0);
        chk("s1_done_valid", bus.skew_valid, 0);

        // Start in the done cycle; cell 5 must still hold 0x06.
        bus.start = 1;
        bus.rd_row = 1;
        step();
        bus.start = 0;
        chk("s2_busy", bus.busy, 1);
        chk("s2_done_clear", bus.done, 0);
        chk("s2_valid_k0", bus.skew_valid, 4'b0001);
        chk("s2_data_k0", bus.skew_out, 32'h00000001);
        chk("cell5_unchanged", bus.row_out, 32'h08070605);
        step();
        step();
        chk("s2_data_k2", bus.skew_out, 32'h00090603);
        step();
        chk("s2_valid_k3", bus.skew_valid, 4'b1111);

        // Reset mid-stream aborts at once and yields no done.
        reset = 1;
        #1;
        chk("abort_valid", bus.skew_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_skew_out", bus.skew_out, 0);
        step();
        reset = 0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            done_seen += int'(bus.done);
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_cells_cleared", bus.row_out, 0);

        // Partial load; write and start in the same cycle.
        bus.wr_en = 1; bus.wr_addr = 4'd0; bus.wr_data = 8'hAA; bus.start = 1;
        step();
        bus.wr_en = 0; bus.start = 0;
        chk("partial_valid_k0", bus.skew_valid, 4'b0001);
        chk("partial_data_k0", bus.skew_out, 32'h000000AA);
        step();
        chk("partial_valid_k1", bus.skew_valid, 4'b0011);
        chk("partial_data_k1", bus.skew_out, 0);
        repeat (6) step();
        chk("partial_done", bus.done, 1);
        bus.rd_row = 0;
        step();
        chk("partial_row0", bus.row_out, 32'h000000AA);

`ifdef MATRIX_SKEW_TRANSPOSE_EN
        load_ramp();
        bus.transpose = 1;
        bus.start = 1;
        step();
        bus.start = 0;
        bus.transpose = 0;
        chk("tr_data_k0", bus.skew_out, 32'h00000001);
        step();
        chk("tr_valid_k1", bus.skew_valid, 4'b0011);
        chk("tr_data_k1", bus.skew_out, 32'h00000205);
        step();
        chk("tr_data_k2", bus.skew_out, 32'h00030609);
        repeat (5) step();
        chk("tr_done", bus.done, 1);
`endif

        // 3x3 instance: address 9 and row 3 are out of range.
        bus_s.wr_en = 1; bus_s.wr_addr = 4'd9; bus_s.wr_data = 8'h77;
        step();
        chk("small_oor_reject", bus_s.wr_reject, 1);
        bus_s.wr_addr = 4'd8; bus_s.wr_data = 8'h33;
        step();
        bus_s.wr_en = 0;
        chk("small_inrange_no_reject", bus_s.wr_reject, 0);
        bus_s.rd_row = 2;
        step();
        chk("small_row2", bus_s.row_out, 24'h330000);
        chk("small_load_done", bus_s.load_done, 0);
        bus_s.rd_row = 3;
        step();
        chk("small_row3_zero", bus_s.row_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
